// File: rtl/modrm_disp_fetch.sv
// ModR/M + displacement fetch FSM feeding 8088 EA generation.
// Optional MODRM_DISP_LEN_EN exposes the fetched displacement length on disp_len_o.
module modrm_disp_fetch (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic        flush_i,
  input  logic [7:0]  in_byte_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic [1:0]  mod_o,
  output logic [2:0]  reg_o,
  output logic [2:0]  rm_o,
  output logic [15:0] disp_o,
  output logic        ea_direct_o,
  output logic        reg_mode_o,
`ifdef MODRM_DISP_LEN_EN
  output logic [1:0]  disp_len_o,
`endif
  output logic        out_valid_o,
  input  logic        out_ready_i
);

  typedef enum logic [2:0] {IDLE, MODRM, DISP_LO, DISP_HI, DONE} state_e;

  state_e      state_q, state_d;
  logic [1:0]  mod_q, mod_d;
  logic [2:0]  reg_q, reg_d;
  logic [2:0]  rm_q, rm_d;
  logic [15:0] disp_q, disp_d;
  logic [1:0]  len_now;

  // Displacement byte count implied by a ModR/M byte.
  always_comb begin
    len_now = 2'd0;
    case (in_byte_i[7:6])
      2'b00:   len_now = (in_byte_i[2:0] == 3'b110) ? 2'd2 : 2'd0;
      2'b01:   len_now = 2'd1;
      2'b10:   len_now = 2'd2;
      default: len_now = 2'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    mod_d   = mod_q;
    reg_d   = reg_q;
    rm_d    = rm_q;
    disp_d  = disp_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start_i) state_d = MODRM;
        MODRM: if (in_valid_i) begin
          mod_d   = in_byte_i[7:6];
          reg_d   = in_byte_i[5:3];
          rm_d    = in_byte_i[2:0];
          disp_d  = 16'h0000;
          state_d = (len_now == 2'd0) ? DONE : DISP_LO;
        end
        DISP_LO: if (in_valid_i) begin
          disp_d[7:0] = in_byte_i;
          // Only mod=01 carries a single (sign-extended) byte; everything else here is disp16.
          if (mod_q == 2'b01) begin
            disp_d[15:8] = {8{in_byte_i[7]}};
            state_d      = DONE;
          end else begin
            state_d = DISP_HI;
          end
        end
        DISP_HI: if (in_valid_i) begin
          disp_d[15:8] = in_byte_i;
          state_d      = DONE;
        end
        DONE: if (out_ready_i) state_d = start_i ? MODRM : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      mod_q   <= 2'b00;
      reg_q   <= 3'b000;
      rm_q    <= 3'b000;
      disp_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      mod_q   <= mod_d;
      reg_q   <= reg_d;
      rm_q    <= rm_d;
      disp_q  <= disp_d;
    end
  end

`ifdef MODRM_DISP_LEN_EN
  logic [1:0] len_q;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      len_q <= 2'd0;
    else if (!flush_i && state_q == MODRM && in_valid_i)
      len_q <= len_now;
  end
  assign disp_len_o = len_q;
`endif

  assign in_ready_o  = (state_q == MODRM) || (state_q == DISP_LO) || (state_q == DISP_HI);
  assign out_valid_o = (state_q == DONE);
  assign mod_o       = mod_q;
  assign reg_o       = reg_q;
  assign rm_o        = rm_q;
  assign disp_o      = disp_q;
  assign ea_direct_o = (mod_q == 2'b00) && (rm_q == 3'b110);
  assign reg_mode_o  = (mod_q == 2'b11);

endmodule

// File: tb/tb_modrm_disp_fetch.sv
// Directed bench for modrm_disp_fetch; expected values are hand-derived from the ModR/M encoding.
module tb_modrm_disp_fetch;
  logic        clk = 1'b0;
  logic        rst_n, start, flush, in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  in_byte;
  logic [1:0]  mod;
  logic [2:0]  rg, rm;
  logic [15:0] disp;
  logic        ea_direct, reg_mode;
`ifdef MODRM_DISP_LEN_EN
  logic [1:0]  disp_len;
`endif
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  modrm_disp_fetch dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .flush_i(flush),
    .in_byte_i(in_byte), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .mod_o(mod), .reg_o(rg), .rm_o(rm), .disp_o(disp),
    .ea_direct_o(ea_direct), .reg_mode_o(reg_mode),
`ifdef MODRM_DISP_LEN_EN
    .disp_len_o(disp_len),
`endif
    .out_valid_o(out_valid), .out_ready_i(out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start at cycle 0, then feed nb bytes (gap idle cycles after the 2nd byte)
  // until out_valid; returns the cycle out_valid rose and bytes consumed.
  task automatic fetch(input logic [7:0] b0, b1, b2, input int nb, input int gap,
                       output int cyc, output int used);
    logic [7:0] bytes [3];
    int idle;
    bytes[0] = b0; bytes[1] = b1; bytes[2] = b2;
    used = 0; idle = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      if (used == 2 && idle < gap) begin
        in_valid = 1'b0;
        idle++;
      end else begin
        in_valid = (used < nb);
        in_byte  = (used < nb) ? bytes[used] : 8'hEE;
      end
      if (in_valid && in_ready) used++;
      step();
      cyc++;
    end
    in_valid = 1'b0;
  endtask

  task automatic release_done();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    int cyc, used;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; in_valid = 1'b0; in_byte = 8'h00; out_ready = 1'b0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_fields", {mod, rg, rm, disp, ea_direct, reg_mode}, 0);
    rst_n = 1'b1;
    step();
    chk("idle_in_ready", in_ready, 0);

    // Register form, no displacement
    fetch(8'hD8, 8'h00, 8'h00, 1, 0, cyc, used);
    chk("rr_latency", cyc, 2);
    chk("rr_fields", {mod, rg, rm}, {2'b11, 3'b011, 3'b000});
    chk("rr_disp", disp, 16'h0000);
    chk("rr_flags", {reg_mode, ea_direct}, 2'b10);
    release_done();
    chk("rr_to_idle", {out_valid, in_ready}, 2'b00);

    // disp8, negative
    fetch(8'h46, 8'hF0, 8'h00, 2, 0, cyc, used);
    chk("d8_latency", cyc, 3);
    chk("d8_modrm", {mod, rm}, {2'b01, 3'b110});
    chk("d8_disp", disp, 16'hFFF0);
    chk("d8_flags", {reg_mode, ea_direct}, 2'b00);
`ifdef MODRM_DISP_LEN_EN
    chk("d8_len", disp_len, 1);
`endif
    release_done();

    // Direct address, disp16
    fetch(8'h06, 8'h34, 8'h12, 3, 0, cyc, used);
    chk("d16_latency", cyc, 4);
    chk("d16_ea_direct", ea_direct, 1);
    chk("d16_disp", disp, 16'h1234);
`ifdef MODRM_DISP_LEN_EN
    chk("d16_len", disp_len, 2);
`endif
    release_done();

    // mod=10 disp16 with a two-cycle bubble between displacement bytes
    fetch(8'h80, 8'h7F, 8'h00, 3, 2, cyc, used);
    chk("gap_latency", cyc, 6);
    chk("gap_used", used, 3);
    chk("gap_disp", disp, 16'h007F);
    chk("gap_mod", mod, 2'b10);

    // Hold in DONE while downstream stalls
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_byte = 8'hAA;
      step();
      chk("hold_valid", out_valid, 1);
      chk("hold_fields", {mod, rg, rm, disp}, {2'b10, 3'b000, 3'b000, 16'h007F});
    end
    in_valid = 1'b0;

    // Back-to-back start on handshake
    out_ready = 1'b1; start = 1'b1;
    step();
    out_ready = 1'b0; start = 1'b0;
    chk("b2b_state", {out_valid, in_ready}, 2'b01);
    in_valid = 1'b1; in_byte = 8'hC1;
    step();
    in_valid = 1'b0;
    chk("b2b_valid", out_valid, 1);
    chk("b2b_fields", {mod, rg, rm, disp}, {2'b11, 3'b000, 3'b001, 16'h0000});
    release_done();

    // Flush in DISP_HI
    start = 1'b1; step(); start = 1'b0;
    in_valid = 1'b1; in_byte = 8'h06; step();
    in_byte = 8'h56; step();
    chk("fl_pre_ready", in_ready, 1);
    flush = 1'b1; in_byte = 8'h99; step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_idle", {out_valid, in_ready}, 2'b00);
    chk("fl_disp_lo_kept", disp[7:0], 8'h56);
    step();
    chk("fl_stays_idle", {out_valid, in_ready}, 2'b00);

    // Asynchronous reset mid-fetch
    start = 1'b1; step(); start = 1'b0;
    in_valid = 1'b1; in_byte = 8'h80; step();
    in_valid = 1'b0;
    chk("ar_pre_mod", mod, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_outputs", {out_valid, in_ready, mod, rg, rm, disp, ea_direct, reg_mode}, 0);
`ifdef MODRM_DISP_LEN_EN
    chk("ar_len", disp_len, 0);
`endif
    #3 rst_n = 1'b1;
    step();
    chk("ar_idle", {out_valid, in_ready}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
